detect_scheduler: RTL and testbench
===================================

DETECT_SCHEDULER -- requirements
Module: detect_scheduler

Interface
REQ-001 SHALL have parameter DATA_W, default 8: width of each requester word; serialised MSB first.
REQ-002 SHALL have parameter CNT_W, default 4: width of match_cnt; DATA_W < 2**CNT_W.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port nRESET  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports req0, req1  input  1 each  job requests from requesters 0 and 1.
REQ-006 SHALL have ports data0, data1  input  DATA_W each  words to scan; sampled only at grant.
REQ-007 SHALL have ports gnt0, gnt1  output  1 each  one-cycle grant pulses; at most one high per cycle.
REQ-008 SHALL have port busy  output  1  high from the grant cycle through the done cycle.
REQ-009 SHALL have port done  output  1  one-cycle pulse; result valid.
REQ-010 SHALL have port owner  output  1  index of the requester whose result is on match_cnt.
REQ-011 SHALL have port match_cnt  output  CNT_W  count of "101" detections in the scanned word.

Function
REQ-012 SHALL implement the states IDLE, SHIFT and DONE.
REQ-013 IDLE: if req0 or req1 is high at a rising edge, the block SHALL choose a winner, load its data into the shift register, clear bit_cnt and match_cnt, pulse the winner's gnt for the next cycle, and go to SHIFT.
REQ-014 Arbitration SHALL be round-robin: when both requests are high, the requester that was not last_owner wins; a single request wins unconditionally.
REQ-015 SHIFT SHALL apply serial bit = shreg[DATA_W-1] to the detector each cycle, shift shreg left by one, and increment bit_cnt.
REQ-016 In SHIFT, when the Mealy detector output is high for the current bit, match_cnt SHALL increment at that edge.
REQ-017 After the DATA_W-th bit, the block SHALL go to DONE.
REQ-018 The detector SHALL be cleared synchronously at each grant, so that no pattern spans two jobs.
REQ-019 DONE SHALL assert done for exactly one cycle with owner and the final match_cnt, then return to IDLE.
REQ-020 Latency: done SHALL be high exactly DATA_W+1 cycles after the grant cycle; a job occupies DATA_W+2 cycles from request sampling to the return to IDLE.
REQ-021 match_cnt and owner SHALL hold their values after done until the next grant.
REQ-022 Requests SHALL be ignored outside IDLE; a requester holding req high after its done SHALL be treated as a new request, subject to round-robin.
REQ-023 The detector SHALL detect "101" with overlap; for example, 1-0-1-0-1 yields 2 detections.

Reset
REQ-024 While nRESET is low, the block SHALL be in IDLE with gnt0=gnt1=busy=done=0, owner=0, match_cnt=0, shreg=0, bit_cnt=0, detector in its start state, and last_owner=1, so that requester 0 wins the first tie.
REQ-025 Reset assertion mid-job SHALL abort the job immediately with no done pulse; after release, the block SHALL resume from IDLE on the first rising edge.

Structure
REQ-026 A shared package SHALL hold the state enum (IDLE/SHIFT/DONE), the detector state enum (S0/S1/S10), and the DATA_W and CNT_W defaults.
REQ-027 The detector SHALL be a sub-module seq101_mealy (clk, nRESET, clr, in, out), a 3-state Mealy machine with combinational out.
REQ-028 Arbiter, counter and shift logic SHALL reside in detect_scheduler.

Verification
REQ-029 Reset then req0=1 with data0=8'b10101010 -> gnt0 pulses 1 cycle; done 9 cycles later; owner=0, match_cnt=3.
REQ-030 req1 only with data1=8'b11011011 -> gnt1; done with owner=1, match_cnt=2; data0=8'h00 job -> match_cnt=0.
REQ-031 req0 and req1 both held high from reset -> grant order 0,1,0,1; never two gnt in one cycle; busy low for exactly 1 cycle between jobs.
REQ-032 req1 raised mid-SHIFT of a req0 job -> no gnt1 until IDLE; the job-0 result is unaffected.
REQ-033 nRESET pulled low at the 4th SHIFT cycle -> all outputs 0 asynchronously, no done; a subsequent req0 job completes normally.
REQ-034 Back-to-back jobs 8'b00000101 then 8'b01000000 -> counts 1 and 0, confirming the detector clears at grant.

Source files
------------

// File: rtl/detect_scheduler_pkg.sv
// Shared types and defaults for the round-robin "101" detect scheduler.
package detect_scheduler_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int CNT_W_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        S0  = 2'd0,
        S1  = 2'd1,
        S10 = 2'd2
    } det_state_t;

endpackage

// File: rtl/seq101_mealy.sv
// Overlapping "101" Mealy detector; out is combinational on the current bit.
// Latency: 0 cycles (out); clr takes priority over the input bit.
module seq101_mealy
    import detect_scheduler_pkg::*;
(
    input  logic clk,
    input  logic nRESET,
    input  logic clr,
    input  logic in,
    output logic out
);

    det_state_t st, st_nxt;

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET)  st <= S0;
        else if (clr) st <= S0;
        else          st <= st_nxt;
    end

    always_comb begin
        st_nxt = st;
        out    = 1'b0;
        case (st)
            S0:  st_nxt = in ? S1 : S0;
            S1:  st_nxt = in ? S1 : S10;
            S10: begin
                // Trailing 1 of a match is also the leading 1 of the next.
                out    = in;
                st_nxt = in ? S1 : S0;
            end
            default: st_nxt = S0;
        endcase
    end

endmodule

// File: rtl/detect_scheduler.sv
// Two-requester round-robin scheduler scanning each granted word for "101".
// Latency: done DATA_W+1 cycles after the grant cycle; requests ignored while busy.
module detect_scheduler
    import detect_scheduler_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              nRESET,
    input  logic              req0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              busy,
    output logic              done,
    output logic              owner,
    output logic [CNT_W-1:0]  match_cnt
);

    state_t            state, state_nxt;
    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  bit_cnt;
    logic              last_owner;
    logic              start, win1, shift_en, det_clr, det_out;

    assign start    = (state == IDLE) && (req0 || req1);
    assign win1     = req1 && (!req0 || !last_owner);
    // The grant cycle is spent clearing the detector; bits flow afterwards.
    assign det_clr  = gnt0 || gnt1;
    assign shift_en = (state == SHIFT) && !det_clr;
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req0 || req1) state_nxt = SHIFT;
            SHIFT:   if (shift_en && (bit_cnt == CNT_W'(DATA_W - 1))) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) state <= IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            shreg      <= '0;
            bit_cnt    <= '0;
            match_cnt  <= '0;
        end else begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            if (start) begin
                gnt0       <= !win1;
                gnt1       <= win1;
                owner      <= win1;
                last_owner <= win1;
                shreg      <= win1 ? data1 : data0;
                bit_cnt    <= '0;
                match_cnt  <= '0;
            end else if (shift_en) begin
                shreg   <= {shreg[DATA_W-2:0], 1'b0};
                bit_cnt <= bit_cnt + CNT_W'(1);
                if (det_out) match_cnt <= match_cnt + CNT_W'(1);
            end
        end
    end

    seq101_mealy u_det (
        .clk    (clk),
        .nRESET (nRESET),
        .clr    (det_clr),
        .in     (shreg[DATA_W-1]),
        .out    (det_out)
    );

endmodule

// File: tb/tb_detect_scheduler.sv
// Directed bench for detect_scheduler: vector table of single jobs plus
// hand-written arbitration, mid-job request and mid-job reset sequences.
module tb_detect_scheduler;

    logic       clk = 1'b0;
    logic       nRESET = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [7:0] data0 = '0, data1 = '0;
    logic       gnt0, gnt1, busy, done, owner;
    logic [3:0] match_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    detect_scheduler #(.DATA_W(8), .CNT_W(4)) dut (
        .clk       (clk),
        .nRESET    (nRESET),
        .req0      (req0),
        .req1      (req1),
        .data0     (data0),
        .data1     (data1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .busy      (busy),
        .done      (done),
        .owner     (owner),
        .match_cnt (match_cnt)
    );

    typedef struct {
        bit         r;
        logic [7:0] d;
        logic [3:0] cnt;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nRESET = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        cyc();
        cyc();
        nRESET = 1'b1;
    endtask

    // Waits (bounded) for a grant; returns whether one appeared.
    task automatic wait_gnt(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cyc();
            if (gnt0 || gnt1) seen = 1'b1;
        end
    endtask

    // Counts cycles after the grant cycle until done (bounded).
    task automatic wait_done(output bit seen, output int n);
        seen = 1'b0;
        n = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            cyc();
            n++;
            if (done) seen = 1'b1;
        end
    endtask

    task automatic run_job(input bit r, input logic [7:0] d, input logic [3:0] exp_cnt,
                           input string tag);
        bit seen;
        int n;
        if (r) begin req1 = 1'b1; data1 = d; end
        else   begin req0 = 1'b1; data0 = d; end
        wait_gnt(seen);
        chk({tag, "_gnt_seen"}, 32'(seen), 1);
        chk({tag, "_gnt_who"}, {gnt1, gnt0}, r ? 2'b10 : 2'b01);
        chk({tag, "_busy_at_gnt"}, 32'(busy), 1);
        req0 = 1'b0;
        req1 = 1'b0;
        cyc();
        chk({tag, "_gnt_one_cycle"}, {gnt1, gnt0}, 0);
        n = 1;
        seen = done;
        for (int i = 0; i < 30 && !seen; i++) begin
            cyc();
            n++;
            if (done) seen = 1'b1;
        end
        chk({tag, "_done_seen"}, 32'(seen), 1);
        chk({tag, "_latency"}, n, 9);
        chk({tag, "_owner"}, 32'(owner), 32'(r));
        chk({tag, "_match_cnt"}, 32'(match_cnt), 32'(exp_cnt));
        chk({tag, "_busy_at_done"}, 32'(busy), 1);
        cyc();
        chk({tag, "_done_pulse"}, {busy, done}, 0);
        chk({tag, "_cnt_hold"}, 32'(match_cnt), 32'(exp_cnt));
        chk({tag, "_owner_hold"}, 32'(owner), 32'(r));
    endtask

    initial begin
        bit seen;
        bit dbl;
        bit late_gnt;
        int n;
        int g;
        int gap;
        bit gw[4];

        vecs[0] = '{r: 1'b0, d: 8'b10101010, cnt: 4'd3};
        vecs[1] = '{r: 1'b1, d: 8'b11011011, cnt: 4'd2};
        vecs[2] = '{r: 1'b0, d: 8'h00,       cnt: 4'd0};
        vecs[3] = '{r: 1'b1, d: 8'b00010101, cnt: 4'd2};
        vecs[4] = '{r: 1'b0, d: 8'hFF,       cnt: 4'd0};
        vecs[5] = '{r: 1'b1, d: 8'b10100101, cnt: 4'd2};
        vecs[6] = '{r: 1'b0, d: 8'b01011010, cnt: 4'd2};

        // Reset state
        #3;
        chk("rst_outputs", {gnt0, gnt1, busy, done, owner}, 0);
        chk("rst_match_cnt", 32'(match_cnt), 0);
        cyc();
        cyc();
        nRESET = 1'b1;
        cyc();
        chk("idle_after_rst", {gnt0, gnt1, busy, done}, 0);

        for (int i = 0; i < 7; i++)
            run_job(vecs[i].r, vecs[i].d, vecs[i].cnt, $sformatf("vec%0d", i));

        // Back-to-back jobs: detector must not carry state between them
        run_job(1'b0, 8'b00000101, 4'd1, "b2b_a");
        run_job(1'b0, 8'b01000000, 4'd0, "b2b_b");

        // Both requests held from reset: alternate starting with requester 0
        do_reset();
        req0 = 1'b1; req1 = 1'b1; data0 = 8'hAA; data1 = 8'hDB;
        g = 0; gap = 0; dbl = 1'b0;
        for (int i = 0; i < 60 && g < 4; i++) begin
            cyc();
            if (gnt0 && gnt1) dbl = 1'b1;
            if (gnt0 || gnt1) begin
                gw[g] = gnt1;
                if (g > 0) chk($sformatf("rr_gap%0d", g), gap, 1);
                g++;
                gap = 0;
            end else if (!busy) begin
                gap++;
            end
        end
        chk("rr_grants", g, 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("rr_order%0d", i), 32'(gw[i]), 32'(i % 2));
        req0 = 1'b0; req1 = 1'b0;
        wait_done(seen, n);
        for (int i = 0; i < 2; i++) begin
            cyc();
            if (gnt0 && gnt1) dbl = 1'b1;
        end
        chk("rr_never_double_gnt", 32'(dbl), 0);
        chk("rr_final_cnt", 32'(match_cnt), 2);

        // req1 raised during a requester-0 job
        req0 = 1'b1; data0 = 8'b10101010;
        wait_gnt(seen);
        chk("mid_gnt0", {gnt1, gnt0}, 2'b01);
        req0 = 1'b0;
        late_gnt = 1'b0;
        for (int i = 0; i < 3; i++) cyc();
        req1 = 1'b1; data1 = 8'hFF;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            if (gnt1) late_gnt = 1'b1;
            if (done) seen = 1'b1;
            else cyc();
        end
        chk("mid_done_seen", 32'(seen), 1);
        chk("mid_no_gnt1_while_busy", 32'(late_gnt), 0);
        chk("mid_owner", 32'(owner), 0);
        chk("mid_cnt", 32'(match_cnt), 3);
        cyc();
        chk("mid_idle_gnt", {gnt1, gnt0}, 0);
        cyc();
        chk("mid_gnt1_after_idle", {gnt1, gnt0}, 2'b10);
        req1 = 1'b0;
        wait_done(seen, n);
        chk("mid_job1_owner", 32'(owner), 1);
        chk("mid_job1_cnt", 32'(match_cnt), 0);
        cyc();

        // Reset asserted on the 4th SHIFT cycle aborts the job
        req1 = 1'b1; data1 = 8'b10101010;
        wait_gnt(seen);
        req1 = 1'b0;
        for (int i = 0; i < 3; i++) cyc();
        chk("abort_pre_owner", 32'(owner), 1);
        chk("abort_pre_busy", 32'(busy), 1);
        nRESET = 1'b0;
        #1;
        chk("abort_outputs", {gnt0, gnt1, busy, done, owner}, 0);
        chk("abort_cnt", 32'(match_cnt), 0);
        late_gnt = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (done || busy) late_gnt = 1'b1;
        end
        chk("abort_no_done", 32'(late_gnt), 0);
        nRESET = 1'b1;
        run_job(1'b0, 8'b10101010, 4'd3, "post_abort");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
